// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared handshake type and counter-width helper for pipeline blocks
package pipe_pkg;

  typedef struct packed {
    logic valid;
    logic ready;
  } hs_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// rtl/pipe_reg_chain_if.sv - upstream/downstream valid-ready stream bundle for pipe_reg_chain
interface pipe_reg_chain_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid/data register pair of the handshaked pipeline
module pipe_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic en;

  // An empty stage always loads, which is what collapses bubbles.
  assign en = ~v | dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= RST_VAL;
    end else if (flush) begin
      v <= 1'b0;
    end else if (en) begin
      v <= up_valid;
      if (up_valid) begin
        d <= up_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - DEPTH-stage handshaked register pipeline; PIPE_REG_CHAIN_COUNT_EN adds occupancy
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_reg_chain_if.slave  bus
`ifdef PIPE_REG_CHAIN_COUNT_EN
  ,
  output logic [cnt_w(DEPTH)-1:0] occupancy
`endif
);

  if (DEPTH < 1) begin : g_depth_chk
    $error("pipe_reg_chain: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   rdy;

  // rdy[i] = !v[i] | rdy[i+1] unrolled: a stage can move if any stage at or
  // after it is empty, or the sink is taking a word.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
    assign rdy[i] = bus.out_ready | ~(&v[DEPTH-1:i]);
  end
  assign rdy[DEPTH] = bus.out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
    end else begin : g_body
      assign up_valid = v[i-1];
      assign up_data  = d[i-1];
    end

    pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (up_valid),
      .up_data  (up_data),
      .dn_ready (rdy[i+1]),
      .v        (v[i]),
      .d        (d[i])
    );
  end

  assign bus.in_ready  = rdy[0] & ~flush;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];

`ifdef PIPE_REG_CHAIN_COUNT_EN
  localparam int CW = cnt_w(DEPTH);

  hs_t  in_hs;
  hs_t  out_hs;
  logic in_xfer;
  logic out_xfer;

  assign in_hs    = '{valid: bus.in_valid, ready: rdy[0] & ~flush};
  assign out_hs   = '{valid: v[DEPTH-1], ready: bus.out_ready};
  assign in_xfer  = in_hs.valid & in_hs.ready;
  assign out_xfer = out_hs.valid & out_hs.ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      occupancy <= occupancy - CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - scoreboard bench for pipe_reg_chain, DEPTH=3
module tb_pipe_reg_chain;
  import pipe_pkg::*;

  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 3;
  localparam logic [7:0] RST_VAL = 8'hA5;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  pipe_reg_chain_if #(.WIDTH(WIDTH)) bus ();

`ifdef PIPE_REG_CHAIN_COUNT_EN
  logic [cnt_w(DEPTH)-1:0] occ;
`endif

  pipe_reg_chain #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef PIPE_REG_CHAIN_COUNT_EN
    ,
    .occupancy (occ)
`endif
  );

  always #5 clk = ~clk;

  int         n_vec     = 0;
  int         n_bad     = 0;
  int         model_cnt = 0;
  bit         model_ok  = 1'b0;
  logic [7:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected output stream: every accepted input word, in order.
  always @(negedge clk) begin
    if (!rst && bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
      sb.push_back(bus.in_data);
  end

  // Output monitor; words in flight are forgotten on rst/flush.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else                chk("sb_data", bus.out_data, sb.pop_front());
    end
    if (rst || flush) sb.delete();
  end

  // Independent word count: drives the in_ready and occupancy expectations.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("in_ready_model", bus.in_ready, !flush && (bus.out_ready || model_cnt < DEPTH));
`ifdef PIPE_REG_CHAIN_COUNT_EN
      chk("occ_model", occ, model_cnt);
`endif
    end
    if (rst || flush) begin
      model_cnt = 0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      model_cnt = model_cnt + int'(bus.in_valid && bus.in_ready)
                            - int'(bus.out_valid && bus.out_ready);
    end
  end

  initial begin
    logic [7:0] nxt;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77;
    bus.out_ready = 1'b0;

    // Reset with input asserted
    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, RST_VAL);
    chk("rst_in_ready", bus.in_ready, 1'b1);
`ifdef PIPE_REG_CHAIN_COUNT_EN
    chk("rst_occ", occ, 0);
`endif

    // Back-to-back stream 0x01..0x0A, first word out three cycles later
    step();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      bus.in_data = 8'(k);
      @(negedge clk);
      chk("stream_in_ready", bus.in_ready, 1'b1);
      chk("stream_out_valid", bus.out_valid, k >= 4);
      if (k >= 4) chk("stream_out_data", bus.out_data, 8'(k - 3));
      step();
    end
    bus.in_valid = 1'b0;
    repeat (4) step();

    // Backpressure: exactly DEPTH words taken, output held
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    nxt = 8'h01;
    for (int c = 0; c < 6; c++) begin
      bus.in_data = nxt;
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, c < 3);
      if (c >= 3) begin
        chk("bp_hold_valid", bus.out_valid, 1'b1);
        chk("bp_hold_data", bus.out_data, 8'h01);
      end
      if (bus.in_ready) nxt++;
      step();
    end
`ifdef PIPE_REG_CHAIN_COUNT_EN
    chk("bp_occ", occ, 3);
`endif
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_drain_valid", bus.out_valid, 1'b1);
      chk("bp_drain_data", bus.out_data, 8'(c + 1));
      step();
    end
    @(negedge clk);
    chk("bp_empty", bus.out_valid, 1'b0);
    step();

    // Sparse input against a stalled output compacts into all stages
    bus.out_ready = 1'b0;
    nxt = 8'h10;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (c % 3 == 0);
      bus.in_data  = nxt;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) nxt++;
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bub_in_ready", bus.in_ready, 1'b0);
    chk("bub_out_data", bus.out_data, 8'h10);
`ifdef PIPE_REG_CHAIN_COUNT_EN
    chk("bub_occ", occ, 3);
`endif
    step();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bub_drain_valid", bus.out_valid, 1'b1);
      chk("bub_drain_data", bus.out_data, 8'h10 + 8'(c));
      step();
    end

    // Flush a full pipe while input is offered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.in_data = 8'h21 + 8'(c);
      step();
    end
    bus.in_data = 8'h99;
    flush       = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", bus.in_ready, 1'b0);
`ifdef PIPE_REG_CHAIN_COUNT_EN
    chk("flush_occ_full", occ, 3);
`endif
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_data_hold", bus.out_data, 8'h21);
`ifdef PIPE_REG_CHAIN_COUNT_EN
    chk("flush_occ", occ, 0);
`endif
    step();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("post_flush_valid", bus.out_valid, j == 3);
      if (j == 3) chk("post_flush_data", bus.out_data, 8'h55);
      step();
      bus.in_valid = 1'b0;
    end

    // Reset in the middle of a stream discards everything
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h31;
    step();
    bus.in_data = 8'h32;
    step();
    rst         = 1'b1;
    bus.in_data = 8'h33;
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_out_data", bus.out_data, RST_VAL);
    step();

    // Random traffic with occasional flush
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_data   = 8'($urandom);
      flush         = ($urandom_range(0, 63) == 0);
      step();
    end
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) step();
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
